time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 157 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Time-of-day keeper with a three-state set-mode controller.
// RUN counts hh:mm:ss on the 1 Hz tick; SET_HOUR and SET_MIN freeze the time
// and let btn_inc edit one field. All outputs come straight from registers.
module time_set_ctrl #(
  parameter int HOURS_MOD = 24
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_1hz_en,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_wrap
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  localparam logic [4:0] HOUR_MAX = 5'(HOURS_MOD - 1);
  localparam logic [5:0] SIXTY_MAX = 6'd59;

  state_t     r_state;
  state_t     w_stateNext;
  logic [4:0] r_hour;
  logic [4:0] w_hourNext;
  logic [5:0] r_minute;
  logic [5:0] w_minuteNext;
  logic [5:0] r_second;
  logic [5:0] w_secondNext;
  logic       r_blink;
  logic       w_blinkNext;
  logic       r_dayWrap;
  logic       w_dayWrapNext;

  logic       w_secAtMax;
  logic       w_minAtMax;
  logic       w_hourAtMax;

  assign w_secAtMax  = (r_second == SIXTY_MAX);
  assign w_minAtMax  = (r_minute == SIXTY_MAX);
  assign w_hourAtMax = (r_hour >= HOUR_MAX);

  // State register: reset forces RUN regardless of any pending edit.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state and next time/blink/wrap values; the whole carry chain resolves here in one cycle.
  always_comb begin
    w_stateNext   = r_state;
    w_hourNext    = r_hour;
    w_minuteNext  = r_minute;
    w_secondNext  = r_second;
    w_blinkNext   = r_blink;
    w_dayWrapNext = 1'b0;

    case (r_state)
      RUN: begin
        w_blinkNext = 1'b0;
        // A tick arriving with btn_mode is still counted before leaving RUN.
        if (tick_1hz_en) begin
          if (w_secAtMax) begin
            w_secondNext = 6'd0;
            if (w_minAtMax) begin
              w_minuteNext = 6'd0;
              if (w_hourAtMax) begin
                w_hourNext    = 5'd0;
                w_dayWrapNext = 1'b1;
              end else begin
                w_hourNext = r_hour + 5'd1;
              end
            end else begin
              w_minuteNext = r_minute + 6'd1;
            end
          end else begin
            w_secondNext = r_second + 6'd1;
          end
        end
        if (btn_mode) begin
          w_stateNext = SET_HOUR;
        end
      end

      SET_HOUR: begin
        // btn_mode wins over btn_inc and over the blink toggle.
        if (btn_mode) begin
          w_stateNext = SET_MIN;
          w_blinkNext = 1'b0;
        end else begin
          if (btn_inc) begin
            w_hourNext = w_hourAtMax ? 5'd0 : r_hour + 5'd1;
          end
          if (tick_1hz_en) begin
            w_blinkNext = ~r_blink;
          end
        end
      end

      SET_MIN: begin
        // Leaving the editor restarts the seconds; a coincident tick is dropped.
        if (btn_mode) begin
          w_stateNext  = RUN;
          w_blinkNext  = 1'b0;
          w_secondNext = 6'd0;
        end else begin
          if (btn_inc) begin
            w_minuteNext = w_minAtMax ? 6'd0 : r_minute + 6'd1;
          end
          if (tick_1hz_en) begin
            w_blinkNext = ~r_blink;
          end
        end
      end

      default: begin
        w_stateNext = RUN;
        w_blinkNext = 1'b0;
      end
    endcase
  end

  // Time, blink and day-wrap registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_hour    <= 5'd0;
      r_minute  <= 6'd0;
      r_second  <= 6'd0;
      r_blink   <= 1'b0;
      r_dayWrap <= 1'b0;
    end else begin
      r_hour    <= w_hourNext;
      r_minute  <= w_minuteNext;
      r_second  <= w_secondNext;
      r_blink   <= w_blinkNext;
      r_dayWrap <= w_dayWrapNext;
    end
  end

  assign hour     = r_hour;
  assign minute   = r_minute;
  assign second   = r_second;
  assign mode     = r_state;
  assign blink    = r_blink;
  assign day_wrap = r_dayWrap;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a 24-hour and a 12-hour instance share the inputs.
// Directed table, hand-written corner sequences, then random traffic against
// a model that keeps the time as seconds-of-day.
module tb_time_set_ctrl;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz_en = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;

  logic [4:0] hour24, hour12;
  logic [5:0] minute24, minute12, second24, second12;
  logic [1:0] mode24, mode12;
  logic       blink24, blink12, dayWrap24, dayWrap12;

  int vectors = 0;
  int miscompares = 0;

  time_set_ctrl #(.HOURS_MOD(24)) u24 (
    .clk_in(clk_in), .rst(rst), .tick_1hz_en(tick_1hz_en),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour(hour24), .minute(minute24), .second(second24),
    .mode(mode24), .blink(blink24), .day_wrap(dayWrap24)
  );

  time_set_ctrl #(.HOURS_MOD(12)) u12 (
    .clk_in(clk_in), .rst(rst), .tick_1hz_en(tick_1hz_en),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hour(hour12), .minute(minute12), .second(second12),
    .mode(mode12), .blink(blink12), .day_wrap(dayWrap12)
  );

  // Free-running system clock.
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic r, t, m, i;
    int   h, mi, s, md, bl, wr;
  } vec_t;

  vec_t tbl[$];

  function automatic void addVec(logic r, logic t, logic m, logic i,
                                 int h, int mi, int s, int md, int bl, int wr);
    vec_t v;
    v.r = r; v.t = t; v.m = m; v.i = i;
    v.h = h; v.mi = mi; v.s = s; v.md = md; v.bl = bl; v.wr = wr;
    tbl.push_back(v);
  endfunction

  // Inputs change on the falling edge; outputs are looked at 1 ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic t, input logic m, input logic i);
    @(negedge clk_in);
    rst = r; tick_1hz_en = t; btn_mode = m; btn_inc = i;
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOne(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int k, input string tag, input int h, input int mi,
                             input int s, input int md, input int bl, input int wr);
    if (k == 0) begin
      checkOne({tag, " hour24"}, int'(hour24), h);
      checkOne({tag, " minute24"}, int'(minute24), mi);
      checkOne({tag, " second24"}, int'(second24), s);
      checkOne({tag, " mode24"}, int'(mode24), md);
      checkOne({tag, " blink24"}, int'(blink24), bl);
      checkOne({tag, " day_wrap24"}, int'(dayWrap24), wr);
    end else begin
      checkOne({tag, " hour12"}, int'(hour12), h);
      checkOne({tag, " minute12"}, int'(minute12), mi);
      checkOne({tag, " second12"}, int'(second12), s);
      checkOne({tag, " mode12"}, int'(mode12), md);
      checkOne({tag, " blink12"}, int'(blink12), bl);
      checkOne({tag, " day_wrap12"}, int'(dayWrap12), wr);
    end
  endtask

  // Reset, then walk the SET path to h:m and return to RUN with seconds at 0.
  task automatic setTime(input int h, input int mi);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < h; n++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < mi; n++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Reference model: time as seconds since midnight, mode as 0/1/2.
  int hmod[2] = '{24, 12};
  int mTime[2];
  int mMode[2];
  int mBlink[2];
  int mWrap[2];

  function automatic void modelStep(int k, bit r, bit t, bit bm, bit bi);
    int h, mi, s;
    if (r) begin
      mTime[k] = 0; mMode[k] = 0; mBlink[k] = 0; mWrap[k] = 0;
      return;
    end
    mWrap[k] = 0;
    h  = mTime[k] / 3600;
    mi = (mTime[k] / 60) % 60;
    s  = mTime[k] % 60;
    if (mMode[k] == 0) begin
      if (t) begin
        mTime[k] = (mTime[k] + 1) % (hmod[k] * 3600);
        if (mTime[k] == 0) mWrap[k] = 1;
      end
      if (bm) begin
        mMode[k] = 1; mBlink[k] = 0;
      end
    end else if (bm) begin
      if (mMode[k] == 2) mTime[k] = mTime[k] - s;
      mMode[k] = (mMode[k] + 1) % 3;
      mBlink[k] = 0;
    end else begin
      if (bi && mMode[k] == 1) h = (h + 1) % hmod[k];
      if (bi && mMode[k] == 2) mi = (mi + 1) % 60;
      if (t) mBlink[k] = 1 - mBlink[k];
      mTime[k] = h * 3600 + mi * 60 + s;
    end
  endfunction

  initial begin
    // Directed table for the 24-hour instance.
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    addVec(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 5; k++) addVec(0, 0, 0, 1, k, 0, 1, 1, 0, 0);
    addVec(0, 1, 0, 0, 5, 0, 1, 1, 1, 0);
    addVec(0, 1, 0, 0, 5, 0, 1, 1, 0, 0);
    addVec(0, 1, 0, 0, 5, 0, 1, 1, 1, 0);
    addVec(0, 0, 1, 0, 5, 0, 1, 2, 0, 0);
    for (int k = 1; k <= 61; k++) addVec(0, 0, 0, 1, 5, k % 60, 1, 2, 0, 0);
    addVec(0, 1, 0, 0, 5, 1, 1, 2, 1, 0);
    addVec(0, 1, 1, 1, 5, 1, 0, 0, 0, 0);
    addVec(0, 1, 0, 1, 5, 1, 1, 0, 0, 0);
    addVec(0, 1, 1, 0, 5, 1, 2, 1, 0, 0);
    addVec(0, 0, 1, 1, 5, 1, 2, 2, 0, 0);
    addVec(0, 0, 1, 0, 5, 1, 0, 0, 0, 0);

    foreach (tbl[n]) begin
      applyStimulus(tbl[n].r, tbl[n].t, tbl[n].m, tbl[n].i);
      checkOutput(0, $sformatf("table[%0d]", n), tbl[n].h, tbl[n].mi, tbl[n].s,
                  tbl[n].md, tbl[n].bl, tbl[n].wr);
    end

    // Carry through midnight on the 24-hour instance.
    setTime(23, 59);
    for (int n = 0; n < 58; n++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "carry 23:59:58", 23, 59, 58, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "carry 23:59:59", 23, 59, 59, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "carry midnight", 0, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(0, "carry wrap drops", 0, 0, 0, 0, 0, 0);

    // Leaving SET_MIN with a coincident tick clears seconds and drops the tick.
    setTime(1, 2);
    for (int n = 0; n < 37; n++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(0, "exit pre", 1, 2, 37, 2, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput(0, "exit", 1, 2, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "exit next tick", 1, 2, 1, 0, 0, 0);

    // 12-hour instance: wrap at 11:59:59 and hour edit rolls 11 -> 0.
    setTime(11, 59);
    for (int n = 0; n < 59; n++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(1, "h12 11:59:59", 11, 59, 59, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(1, "h12 midnight", 0, 0, 0, 0, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(1, "h12 set entry", 0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 11; n++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(1, "h12 hour 11", 11, 0, 0, 1, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput(1, "h12 hour roll", 0, 0, 0, 1, 0, 0);

    // Reset mid-edit, sampled only on a clock edge.
    setTime(12, 34);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "rst pre", 12, 34, 0, 2, 1, 0);
    @(negedge clk_in);
    rst = 1'b1; tick_1hz_en = 1'b0; btn_mode = 1'b0; btn_inc = 1'b1;
    #2;
    checkOutput(0, "rst between edges", 12, 34, 0, 2, 1, 0);
    @(posedge clk_in);
    #1;
    checkOutput(0, "rst applied", 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "rst first tick", 0, 0, 1, 0, 0, 0);

    // Random traffic against the model on both instances.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    modelStep(0, 1'b1, 1'b0, 1'b0, 1'b0);
    modelStep(1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 20000; n++) begin
      bit r, t, bm, bi;
      r  = ($urandom_range(0, 499) == 0);
      t  = ($urandom_range(0, 2) != 0);
      bm = ($urandom_range(0, 15) == 0);
      bi = ($urandom_range(0, 2) == 0);
      modelStep(0, r, t, bm, bi);
      modelStep(1, r, t, bm, bi);
      applyStimulus(r, t, bm, bi);
      for (int k = 0; k < 2; k++) begin
        checkOutput(k, $sformatf("rand[%0d]", n), mTime[k] / 3600, (mTime[k] / 60) % 60,
                    mTime[k] % 60, mMode[k], mBlink[k], mWrap[k]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
